// File: rtl/ins_fetch_queue.sv
// Instruction fetch queue: issues sequential ROM reads and buffers {word, pc} pairs
// for the instruction splitter, with redirect flush and one-cycle ROM read latency.
module ins_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        rom_req,
  output logic [15:0] rom_addr,
  input  logic [15:0] rom_data,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [15:0] ins_data,
  output logic [15:0] ins_pc,
  output logic [3:0]  count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [15:0]     fetch_pc_q, fetch_pc_d;
  logic            inflight_q, inflight_d;
  logic [15:0]     inflight_pc_q, inflight_pc_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [3:0]      count_q, count_d;
  logic [15:0]     word_mem [DEPTH];
  logic [15:0]     pc_mem   [DEPTH];
  logic            push, pop;

  // A slot is reserved for the in-flight read; a same-cycle pop earns no credit.
  always_comb begin
    rom_req   = en & ~rst & ~redirect &
                (({1'b0, count_q} + {4'b0000, inflight_q}) < 5'(DEPTH));
    rom_addr  = fetch_pc_q;
    ins_valid = (count_q != 4'd0);
    ins_data  = word_mem[rd_ptr_q];
    ins_pc    = pc_mem[rd_ptr_q];
    count     = count_q;
    push      = inflight_q & ~redirect;
    pop       = ins_valid & ins_ready & ~redirect;
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      inflight_d = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = 4'd0;
    end else begin
      inflight_d = rom_req;
      if (rom_req) begin
        inflight_pc_d = fetch_pc_q;
        fetch_pc_d    = fetch_pc_q + 16'd1;
      end
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + 4'd1;
        2'b01:   count_d = count_q - 4'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 16'h0000;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= 4'd0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
    end
  end

  // Storage is not reset; count gates visibility of stale entries.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      word_mem[wr_ptr_q] <= rom_data;
      pc_mem[wr_ptr_q]   <= inflight_pc_q;
    end
  end

endmodule

// File: tb/tb_ins_fetch_queue.sv
// Bench for ins_fetch_queue: directed scenarios plus randomized traffic checked
// against a queue-based transaction model.
module tb_ins_fetch_queue;
  localparam int unsigned DEPTH    = 4;
  localparam logic [15:0] RESET_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst, en, redirect, ins_ready;
  logic [15:0] rom_data, redirect_pc;
  logic        rom_req, ins_valid;
  logic [15:0] rom_addr, ins_data, ins_pc;
  logic [3:0]  count;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [15:0] m_fetch_pc;
  bit          m_inflight;
  logic [15:0] m_inflight_pc;
  logic [31:0] m_q[$];

  always #5 clk = ~clk;

  ins_fetch_queue #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .rom_req     (rom_req),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ins_valid   (ins_valid),
    .ins_ready   (ins_ready),
    .ins_data    (ins_data),
    .ins_pc      (ins_pc),
    .count       (count)
  );

  function automatic logic [15:0] rom_word(input logic [15:0] a);
    return 16'hA000 + a;
  endfunction

  function automatic bit exp_req();
    return en && !rst && !redirect && ((m_q.size() + int'(m_inflight)) < int'(DEPTH));
  endfunction

  task automatic drive(input bit r, input bit e, input bit rd, input bit rdy,
                       input logic [15:0] rpc);
    rst = r; en = e; redirect = rd; ins_ready = rdy; redirect_pc = rpc;
    #1;
  endtask

  // Advance one clock: update the model, then answer the ROM one cycle later.
  task automatic tick();
    logic        req_seen;
    logic [15:0] addr_seen;
    bit          e_req;
    req_seen  = rom_req;
    addr_seen = rom_addr;
    e_req     = exp_req();
    @(posedge clk);
    if (rst) begin
      m_fetch_pc = RESET_PC; m_inflight = 1'b0; m_q.delete();
    end else if (redirect) begin
      m_fetch_pc = redirect_pc; m_inflight = 1'b0; m_q.delete();
    end else begin
      if (m_q.size() != 0 && ins_ready) void'(m_q.pop_front());
      if (m_inflight) m_q.push_back({rom_data, m_inflight_pc});
      m_inflight = e_req;
      if (e_req) begin
        m_inflight_pc = m_fetch_pc;
        m_fetch_pc    = m_fetch_pc + 16'd1;
      end
    end
    #1;
    rom_data = req_seen ? rom_word(addr_seen) : 16'($urandom);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 16'h0000);
    tick();
  endtask

  task automatic test_reset();
    drive(1, 1, 1, 1, 16'h5555);
    n_checks++;
    if (rom_req !== 1'b0) $display("FAIL reset_req got %b want 0", rom_req);
    else n_pass++;
    tick();
    drive(0, 0, 0, 0, 16'h0000);
    n_checks++;
    if (count !== 4'd0) $display("FAIL reset_count got %0d want 0", count);
    else n_pass++;
    n_checks++;
    if (ins_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", ins_valid);
    else n_pass++;
    n_checks++;
    if (rom_addr !== RESET_PC) $display("FAIL reset_addr got %h want %h", rom_addr, RESET_PC);
    else n_pass++;
    n_checks++;
    if (rom_req !== 1'b0) $display("FAIL reset_idle_req got %b want 0", rom_req);
    else n_pass++;
    tick();
  endtask

  task automatic test_stream();
    do_reset();
    for (int c = 0; c < 12; c++) begin
      drive(0, 1, 0, 1, 16'h0000);
      n_checks++;
      if (rom_req !== 1'b1 || rom_addr !== 16'(c))
        $display("FAIL stream_req c=%0d got %b/%h want 1/%h", c, rom_req, rom_addr, 16'(c));
      else n_pass++;
      n_checks++;
      if (c >= 2) begin
        if (ins_valid !== 1'b1 || ins_pc !== 16'(c - 2) || ins_data !== rom_word(16'(c - 2)) ||
            count !== 4'd1)
          $display("FAIL stream_out c=%0d got v=%b pc=%h d=%h n=%0d want 1/%h/%h/1", c,
                   ins_valid, ins_pc, ins_data, count, 16'(c - 2), rom_word(16'(c - 2)));
        else n_pass++;
      end else begin
        if (ins_valid !== 1'b0 || count !== 4'd0)
          $display("FAIL stream_fill c=%0d got v=%b n=%0d want 0/0", c, ins_valid, count);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_fill();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(0, 1, 0, 0, 16'h0000);
      n_checks++;
      if (rom_req !== (c < 4) || (c < 4 && rom_addr !== 16'(c)))
        $display("FAIL fill_req c=%0d got %b/%h want %b/%h", c, rom_req, rom_addr,
                 (c < 4), 16'(c));
      else n_pass++;
      tick();
    end
    drive(0, 1, 0, 0, 16'h0000);
    n_checks++;
    if (count !== 4'(DEPTH)) $display("FAIL fill_count got %0d want %0d", count, DEPTH);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, 1, 16'h0000);
      if (i == 0) begin
        n_checks++;
        if (rom_req !== 1'b0) $display("FAIL fill_full_req got %b want 0", rom_req);
        else n_pass++;
      end
      n_checks++;
      if (ins_valid !== 1'b1 || ins_pc !== 16'(i) || ins_data !== rom_word(16'(i)))
        $display("FAIL fill_drain i=%0d got v=%b pc=%h d=%h want 1/%h/%h", i, ins_valid,
                 ins_pc, ins_data, 16'(i), rom_word(16'(i)));
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_redirect();
    logic [15:0] e_pc;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      drive(0, 1, 0, c < 4, 16'h0000);
      tick();
    end
    drive(0, 1, 1, 0, 16'h0040);
    n_checks++;
    if (count !== 4'd3 || rom_req !== 1'b0)
      $display("FAIL redir_pre got n=%0d req=%b want 3/0", count, rom_req);
    else n_pass++;
    tick();
    drive(0, 1, 0, 1, 16'h0000);
    n_checks++;
    if (count !== 4'd0 || ins_valid !== 1'b0 || rom_req !== 1'b1 || rom_addr !== 16'h0040)
      $display("FAIL redir_flush got n=%0d v=%b req=%b a=%h want 0/0/1/0040", count,
               ins_valid, rom_req, rom_addr);
    else n_pass++;
    tick();
    drive(0, 1, 0, 1, 16'h0000);
    n_checks++;
    if (ins_valid !== 1'b0) $display("FAIL redir_gap got v=%b want 0", ins_valid);
    else n_pass++;
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(0, 1, 0, 1, 16'h0000);
      e_pc = 16'h0040 + 16'(i);
      n_checks++;
      if (ins_valid !== 1'b1 || ins_pc !== e_pc || ins_data !== rom_word(e_pc))
        $display("FAIL redir_out i=%0d got v=%b pc=%h d=%h want 1/%h/%h", i, ins_valid,
                 ins_pc, ins_data, e_pc, rom_word(e_pc));
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [15:0] e_pc;
    drive(0, 1, 1, 1, 16'hFFFE);
    tick();
    drive(0, 1, 0, 1, 16'h0000);
    n_checks++;
    if (rom_req !== 1'b1 || rom_addr !== 16'hFFFE)
      $display("FAIL wrap_req got %b/%h want 1/fffe", rom_req, rom_addr);
    else n_pass++;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 0, 1, 16'h0000);
      e_pc = 16'hFFFE + 16'(i);
      n_checks++;
      if (ins_valid !== 1'b1 || ins_pc !== e_pc || ins_data !== rom_word(e_pc))
        $display("FAIL wrap_out i=%0d got v=%b pc=%h d=%h want 1/%h/%h", i, ins_valid,
                 ins_pc, ins_data, e_pc, rom_word(e_pc));
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_reset_midop();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive(0, 1, 0, 0, 16'h0000);
      tick();
    end
    drive(1, 1, 1, 1, 16'h1234);
    n_checks++;
    if (count !== 4'd2 || rom_req !== 1'b0)
      $display("FAIL rstmid_pre got n=%0d req=%b want 2/0", count, rom_req);
    else n_pass++;
    tick();
    drive(0, 0, 0, 0, 16'h0000);
    n_checks++;
    if (count !== 4'd0 || ins_valid !== 1'b0 || rom_addr !== RESET_PC)
      $display("FAIL rstmid_post got n=%0d v=%b a=%h want 0/0/%h", count, ins_valid,
               rom_addr, RESET_PC);
    else n_pass++;
    tick();
    drive(0, 1, 0, 1, 16'h0000);
    tick();
    tick();
    drive(0, 1, 0, 1, 16'h0000);
    n_checks++;
    if (ins_valid !== 1'b1 || ins_pc !== RESET_PC || count !== 4'd1)
      $display("FAIL rstmid_resume got v=%b pc=%h n=%0d want 1/%h/1", ins_valid, ins_pc,
               count, RESET_PC);
    else n_pass++;
    tick();
  endtask

  task automatic test_random();
    bit          have_last = 1'b0;
    logic [15:0] last_pc = 16'h0000;
    logic [15:0] rpc;
    bit          e, rdy, rd;
    for (int c = 0; c < 1000; c++) begin
      e   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 1) != 0);
      rd  = ($urandom_range(0, 49) == 0);
      rpc = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'hFFFD;
      drive(0, e, rd, rdy, rpc);
      n_checks++;
      if (rom_req !== exp_req() || rom_addr !== m_fetch_pc)
        $display("FAIL rand_req c=%0d got %b/%h want %b/%h", c, rom_req, rom_addr,
                 exp_req(), m_fetch_pc);
      else n_pass++;
      n_checks++;
      if (count !== 4'(m_q.size()) || ins_valid !== (m_q.size() != 0))
        $display("FAIL rand_count c=%0d got n=%0d v=%b want %0d", c, count, ins_valid,
                 m_q.size());
      else n_pass++;
      n_checks++;
      if (count > 4'(DEPTH)) $display("FAIL rand_bound c=%0d got %0d max %0d", c, count, DEPTH);
      else n_pass++;
      if (m_q.size() != 0) begin
        n_checks++;
        if ({ins_data, ins_pc} !== m_q[0])
          $display("FAIL rand_head c=%0d got %h/%h want %h/%h", c, ins_data, ins_pc,
                   m_q[0][31:16], m_q[0][15:0]);
        else n_pass++;
      end
      if (rd) begin
        have_last = 1'b0;
      end else if (ins_valid && rdy) begin
        if (have_last) begin
          n_checks++;
          if (ins_pc !== last_pc + 16'd1)
            $display("FAIL rand_seq c=%0d got %h want %h", c, ins_pc, last_pc + 16'd1);
          else n_pass++;
        end
        have_last = 1'b1;
        last_pc   = ins_pc;
      end
      tick();
    end
  endtask

  initial begin
    rom_data = 16'h0000;
    drive(1, 0, 0, 0, 16'h0000);
    test_reset();
    test_stream();
    test_fill();
    test_redirect();
    test_wrap();
    test_reset_midop();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ins_fetch_queue.md
INS_FETCH_QUEUE -- requirements
Module: ins_fetch_queue

Interface
REQ-001 Parameter DEPTH, 4, number of instruction entries held for the decoder (power of two, 2..8).
REQ-002 Parameter RESET_PC, 16'h0000, fetch address loaded on reset.
REQ-003 The block SHALL use a single clock and a synchronous, active-high reset; no other clock or asynchronous input is used.
REQ-004 clk  in  1  rising-edge clock, shared with the CPU core.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 en  in  1  fetch enable; 0 stops new ROM requests, already-queued entries still drain.
REQ-007 rom_req  out  1  ROM read strobe for the current cycle.
REQ-008 rom_addr  out  16  instruction ROM address, valid when rom_req=1.
REQ-009 rom_data  in  16  ROM read data, valid exactly one cycle after the matching rom_req.
REQ-010 redirect  in  1  branch/jump taken; flush and refetch.
REQ-011 redirect_pc  in  16  new fetch address, sampled when redirect=1.
REQ-012 ins_valid  out  1  head entry present for the instruction splitter.
REQ-013 ins_ready  in  1  instruction splitter accepts head (load strobe).
REQ-014 ins_data  out  16  head instruction word.
REQ-015 ins_pc  out  16  ROM address the head word was fetched from.
REQ-016 count  out  4  number of valid queue entries, 0..DEPTH.

Function
REQ-017 Internal state: fetch_pc (16b), inflight flag (1b), circular queue of DEPTH {word, pc} entries with read/write pointers, count.
REQ-018 rom_req SHALL be 1 iff en=1, rst=0, redirect=0 and count + inflight + (pending write this cycle) leaves a free slot, i.e. (count + inflight) < DEPTH, with the pop credit ignored.
REQ-019 rom_addr SHALL equal fetch_pc combinationally; fetch_pc increments by 1 on each cycle with rom_req=1, wrapping 16'hFFFF -> 16'h0000.
REQ-020 inflight SHALL be set on the cycle after rom_req=1 and cleared otherwise; while set, rom_data with its address is written into the queue at the end of that cycle.
REQ-021 A pop occurs when ins_valid=1 and ins_ready=1; ins_data/ins_pc advance to the next entry on the following cycle.
REQ-022 ins_valid SHALL equal (count != 0); ins_data/ins_pc are driven from the head entry and are don't-care when ins_valid=0.
REQ-023 Simultaneous push and pop SHALL leave count unchanged; the queue never overflows (guaranteed by REQ-018) and ins_ready with count=0 has no effect.
REQ-024 Latency: rom_req in cycle N -> entry visible (ins_valid=1 if queue was empty) in cycle N+2.
REQ-025 On redirect=1: rom_req=0 that cycle; at the clock edge count:=0, pointers:=0, fetch_pc:=redirect_pc, inflight:=0; any rom_data returning in that cycle is discarded; a concurrent pop is discarded.
REQ-026 Fetch resumes in the cycle after redirect, at redirect_pc, if en=1.
REQ-027 Deassertion of en SHALL not cancel a request already issued; its data is still queued.
REQ-028 Sustained throughput with ins_ready=1 and en=1 SHALL be one instruction per cycle after the initial 2-cycle fill.

Reset
REQ-029 rst=1 SHALL override all inputs, including redirect, for that edge.
REQ-030 After reset: fetch_pc=RESET_PC, count=0, ins_valid=0, inflight=0, pointers=0, rom_req=0 during the reset cycle; queue storage need not be cleared.
REQ-031 Reset asserted mid-operation SHALL drop all queued and in-flight instructions; no entry fetched before reset appears afterwards.

Verification
REQ-032 Reset release, en=1, ins_ready=1, ROM[i]=16'hA000+i -> rom_req cycles 0,1,2..; ins_valid from cycle 2; ins_data/ins_pc = A000/0000, A001/0001, ... one per cycle.
REQ-033 en=1, ins_ready=0 -> exactly DEPTH requests (addr 0..3), count=4, rom_req=0 thereafter; raise ins_ready -> words 0..3 in order, then refetch from addr 4.
REQ-034 Queue holding 3 entries, in-flight read of addr 5, redirect=1 with redirect_pc=16'h0040 -> next cycle count=0, ins_valid=0, data for addr 5 never output; ins_pc=0040 two cycles after fetch resumes.
REQ-035 redirect_pc=16'hFFFE, ins_ready=1 -> ins_pc sequence FFFE, FFFF, 0000, 0001.
REQ-036 Random ins_ready/en toggling for 1000 cycles -> output pc sequence strictly consecutive, count never exceeds DEPTH, no word lost or duplicated versus scoreboard.
REQ-037 rst=1 for one cycle while count=2 and redirect=1 -> next cycle count=0, rom_addr=RESET_PC.
